// File: rtl/i2c_cmd_sequencer_if.sv
// Command stream from the lock controller plus the peripheral_i2c register bus.
// The sequencer uses the master view; the command source and peripheral use the slave view.
interface i2c_cmd_sequencer_if;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] i2c_d_in;
  logic [3:0]  i2c_addr;
  logic        i2c_cs;
  logic        i2c_wr;
  logic        i2c_rd;
  logic [7:0]  i2c_d_out;

  modport master (
    input  cmd_data, cmd_valid, i2c_d_out,
    output cmd_ready, i2c_d_in, i2c_addr, i2c_cs, i2c_wr, i2c_rd
  );

  modport slave (
    output cmd_data, cmd_valid, i2c_d_out,
    input  cmd_ready, i2c_d_in, i2c_addr, i2c_cs, i2c_wr, i2c_rd
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Buffers 16-bit I2C commands in a FIFO and drains them one at a time into peripheral_i2c:
// load word, start pulse, then poll status until done, NACK or poll timeout.
module i2c_cmd_sequencer #(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_POLL = 4096
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  i2c_cmd_sequencer_if.master bus,
  output logic                seq_busy,
  output logic                err_ack,
  output logic                err_timeout,
  input  logic                clr_err,
  output logic [7:0]          sent_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TIMEOUT_POLL + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(TIMEOUT_POLL);

  typedef enum logic [2:0] {IDLE, LOAD, GO, CLR, POLL, CHK} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [PW-1:0] poll_cnt, poll_cnt_nxt;
  logic          set_ack, set_timeout, inc_sent;
  logic          cs_nxt, wr_nxt, rd_nxt, cs_q, wr_q, rd_q;
  logic [3:0]    addr_nxt, addr_q;
  logic [15:0]   d_nxt, d_q;
  logic [5:0]    status_unused;

  // Equal indices mean empty when the wrap bits match, full when they differ.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;
  assign seq_busy      = !empty || (state != IDLE);
  assign status_unused = bus.i2c_d_out[7:2];

  // NOTE: the storage array has no reset; only the pointers decide which entries are live.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.cmd_data;
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    pop          = 1'b0;
    set_ack      = 1'b0;
    set_timeout  = 1'b0;
    inc_sent     = 1'b0;
    unique case (state)
      IDLE: if (!empty) state_nxt = LOAD;
      LOAD: state_nxt = GO;
      GO:   state_nxt = CLR;
      CLR: begin
        poll_cnt_nxt = '0;
        state_nxt    = POLL;
      end
      POLL: state_nxt = CHK;
      CHK: begin
        if (bus.i2c_d_out[0]) begin
          poll_cnt_nxt = poll_cnt + 1'b1;
          if (poll_cnt_nxt == POLL_LIMIT) begin
            set_timeout = 1'b1;
            pop         = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = POLL;
          end
        end else begin
          pop       = 1'b1;
          state_nxt = IDLE;
          if (bus.i2c_d_out[1]) set_ack  = 1'b1;
          else                  inc_sent = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cs_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    rd_nxt   = 1'b0;
    addr_nxt = '0;
    d_nxt    = '0;
    case (state_nxt)
      LOAD: begin cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = 4'd2; d_nxt = mem[rd_ptr[AW-1:0]]; end
      GO:   begin cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = 4'd0; d_nxt = 16'h0001; end
      CLR:  begin cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = 4'd0; d_nxt = 16'h0000; end
      POLL: begin cs_nxt = 1'b1; rd_nxt = 1'b1; addr_nxt = 4'd4; end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state    <= IDLE;
      poll_cnt <= '0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      d_q      <= '0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
      cs_q     <= cs_nxt;
      wr_q     <= wr_nxt;
      rd_q     <= rd_nxt;
      addr_q   <= addr_nxt;
      d_q      <= d_nxt;
    end
  end

  assign bus.i2c_cs   = cs_q;
  assign bus.i2c_wr   = wr_q;
  assign bus.i2c_rd   = rd_q;
  assign bus.i2c_addr = addr_q;
  assign bus.i2c_d_in = d_q;

  // A clear in the same cycle as a new error wins.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      err_ack     <= 1'b0;
      err_timeout <= 1'b0;
      sent_count  <= 8'd0;
    end else begin
      if (clr_err) begin
        err_ack     <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (set_ack)     err_ack     <= 1'b1;
        if (set_timeout) err_timeout <= 1'b1;
      end
      if (inc_sent) sent_count <= sent_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: scripted peripheral status responder, a queue-based model of
// the expected bus traffic and counters checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  typedef struct { logic [15:0] cmd; int busy; logic [7:0] fin; } cmd_t;
  typedef struct { logic rd; logic [3:0] addr; logic [15:0] d; int gap; } acc_t;
  typedef struct { int cyc; logic rd; logic [3:0] addr; logic [15:0] d; } log_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err = 1'b0;
  logic       seq_busy, err_ack, err_timeout;
  logic [7:0] sent_count;

  i2c_cmd_sequencer_if bus();

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_POLL(TIMEOUT)) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst_n),
    .bus        (bus),
    .seq_busy   (seq_busy),
    .err_ack    (err_ack),
    .err_timeout(err_timeout),
    .clr_err    (clr_err),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Script for the command being pushed: busy polls before the final status byte.
  int         cmd_busy = 0;
  logic [7:0] cmd_final = 8'h00;

  cmd_t exp_fifo[$];
  acc_t exp_acc[$];
  log_t acc_log[$];
  logic [7:0] m_sent;
  bit   m_ack, m_to, pop_arm, pop_due, m_ready;
  int   m_n, last_acc_cyc = 0;
  cmd_t m_c;
  acc_t m_e;

  // Peripheral status responder: status is registered on the read cycle.
  int rd_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i2c_d_out <= 8'h00;
      rd_seen       <= 0;
    end else if (bus.i2c_cs && bus.i2c_wr && bus.i2c_addr == 4'd2) begin
      rd_seen <= 0;
    end else if (bus.i2c_cs && bus.i2c_rd) begin
      rd_seen <= rd_seen + 1;
      if (exp_fifo.size() == 0)            bus.i2c_d_out <= 8'h00;
      else if (rd_seen < exp_fifo[0].busy) bus.i2c_d_out <= 8'h01;
      else                                 bus.i2c_d_out <= exp_fifo[0].fin;
    end
  end

  // Model and per-cycle compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fifo.delete();
      exp_acc.delete();
      m_sent = 8'd0; m_ack = 1'b0; m_to = 1'b0; pop_arm = 1'b0; pop_due = 1'b0;
      check("rst_cs", bus.i2c_cs, 0);
      check("rst_wr_rd", {bus.i2c_wr, bus.i2c_rd}, 0);
      check("rst_addr", bus.i2c_addr, 0);
      check("rst_d_in", bus.i2c_d_in, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_seq_busy", seq_busy, 0);
      check("rst_errors", {err_ack, err_timeout}, 0);
      check("rst_sent_count", sent_count, 0);
    end else begin
      if (bus.i2c_cs) begin
        check("one_strobe", bus.i2c_wr ^ bus.i2c_rd, 1);
        acc_log.push_back('{cyc: cyc, rd: bus.i2c_rd, addr: bus.i2c_addr, d: bus.i2c_d_in});
        if (exp_acc.size() == 0 && exp_fifo.size() != 0) begin
          m_c = exp_fifo[0];
          m_n = (m_c.busy + 1 < TIMEOUT) ? m_c.busy + 1 : TIMEOUT;
          exp_acc.push_back('{rd: 1'b0, addr: 4'd2, d: m_c.cmd, gap: 0});
          exp_acc.push_back('{rd: 1'b0, addr: 4'd0, d: 16'h0001, gap: 1});
          exp_acc.push_back('{rd: 1'b0, addr: 4'd0, d: 16'h0000, gap: 1});
          for (int i = 0; i < m_n; i++)
            exp_acc.push_back('{rd: 1'b1, addr: 4'd4, d: 16'h0000, gap: (i == 0) ? 1 : 2});
        end
        if (exp_acc.size() == 0) begin
          check("spurious_access", bus.i2c_cs, 0);
        end else begin
          m_e = exp_acc.pop_front();
          check("acc_rd", bus.i2c_rd, m_e.rd);
          check("acc_addr", bus.i2c_addr, m_e.addr);
          if (!m_e.rd) check("acc_d_in", bus.i2c_d_in, m_e.d);
          if (m_e.gap != 0) check("acc_gap", cyc - last_acc_cyc, m_e.gap);
          if (exp_acc.size() == 0) pop_arm = 1'b1;
        end
        last_acc_cyc = cyc;
      end else begin
        check("idle_strobes", {bus.i2c_wr, bus.i2c_rd}, 0);
      end
      check("cmd_ready", bus.cmd_ready, exp_fifo.size() < DEPTH);
      check("seq_busy", seq_busy, exp_fifo.size() != 0);
      check("err_ack", err_ack, m_ack);
      check("err_timeout", err_timeout, m_to);
      check("sent_count", sent_count, m_sent);

      // Advance the model across the coming rising edge.
      m_ready = exp_fifo.size() < DEPTH;
      if (pop_due && exp_fifo.size() != 0) begin
        m_c = exp_fifo.pop_front();
        if (m_c.busy >= TIMEOUT) m_to = 1'b1;
        else if (m_c.fin[1])     m_ack = 1'b1;
        else                     m_sent = m_sent + 8'd1;
      end
      pop_due = pop_arm;
      pop_arm = 1'b0;
      if (clr_err) begin m_ack = 1'b0; m_to = 1'b0; end
      if (bus.cmd_valid && m_ready)
        exp_fifo.push_back('{cmd: bus.cmd_data, busy: cmd_busy, fin: cmd_final});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input int busy, input logic [7:0] fin, output int waited);
    int n = 0;
    bus.cmd_data  = d;
    cmd_busy      = busy;
    cmd_final     = fin;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_accept", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    waited = n;
  endtask

  task automatic drain();
    int n = 0;
    while ((seq_busy || exp_fifo.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_done", seq_busy, 0);
  endtask

  logic [3:0]  t2_addr [7] = '{4'd2, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4};
  logic [15:0] t2_d    [3] = '{16'hA050, 16'h0001, 16'h0000};
  int          t2_off  [7] = '{2, 3, 4, 5, 7, 9, 11};

  initial begin
    int w, push_cyc, n;
    logic [15:0] loads[$];
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'h0000;

    // 1: reset held while a command is offered
    repeat (2) tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'h1234;
    repeat (3) tick();
    check("t1_ready_in_reset", bus.cmd_ready, 1);
    check("t1_cs_in_reset", bus.i2c_cs, 0);
    check("t1_busy_in_reset", seq_busy, 0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t1_idle_after_release", seq_busy, 0);
    check("t1_no_bus_after_release", bus.i2c_cs, 0);

    // 2: single command, 3 busy polls then done
    acc_log.delete();
    push_cyc = cyc;
    push(16'hA050, 3, 8'h00, w);
    drain();
    check("t2_access_count", acc_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < acc_log.size()) begin
        check("t2_addr", acc_log[i].addr, t2_addr[i]);
        check("t2_is_read", acc_log[i].rd, i >= 3);
        check("t2_cycle", acc_log[i].cyc - push_cyc, t2_off[i]);
        if (i < 3) check("t2_d_in", acc_log[i].d, t2_d[i]);
      end
    end
    check("t2_sent", sent_count, 1);

    // 3: fill the FIFO behind a long command, 9th push held off
    acc_log.delete();
    push(16'h5000, 12, 8'h00, w);
    for (int i = 1; i < 8; i++) push(16'(16'h5000 + i), 0, 8'h00, w);
    check("t3_full_ready_low", bus.cmd_ready, 0);
    push(16'h5008, 0, 8'h00, w);
    check("t3_ninth_held_off", w >= 15, 1);
    drain();
    loads.delete();
    foreach (acc_log[i]) if (!acc_log[i].rd && acc_log[i].addr == 4'd2) loads.push_back(acc_log[i].d);
    check("t3_load_count", loads.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < loads.size()) check("t3_load_order", loads[i], 16'(16'h5000 + i));
    check("t3_sent", sent_count, 10);

    // 4: NACK then a good command, then clear
    push(16'hB0AA, 0, 8'h02, w);
    push(16'hB0BB, 1, 8'h00, w);
    drain();
    check("t4_err_ack", err_ack, 1);
    check("t4_sent", sent_count, 11);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check("t4_err_ack_cleared", err_ack, 0);

    // 5: stuck busy -> timeout after exactly TIMEOUT reads
    acc_log.delete();
    push(16'hC0DE, 1000, 8'h00, w);
    drain();
    n = 0;
    foreach (acc_log[i]) if (acc_log[i].rd) n++;
    check("t5_reads", n, 16);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_sent_unchanged", sent_count, 11);
    push(16'hC0DF, 0, 8'h00, w);
    drain();
    check("t5_next_runs", sent_count, 12);

    // 6: async reset during a status poll
    push(16'hD000, 10, 8'h00, w);
    push(16'hD001, 0, 8'h00, w);
    n = 0;
    while (!bus.i2c_rd && n < 200) begin tick(); n++; end
    check("t6_in_poll", bus.i2c_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_cs_dropped", bus.i2c_cs, 0);
    check("t6_rd_dropped", bus.i2c_rd, 0);
    check("t6_fifo_empty", {bus.cmd_ready, seq_busy}, 2'b10);
    check("t6_sent_cleared", sent_count, 0);
    check("t6_timeout_cleared", err_timeout, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(16'hD002, 0, 8'h00, w);
    drain();
    check("t6_after_reset", sent_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
